frame_transmit_bdeduffy: RTL
============================

// Module: frame_transmit_bdeduffy
// PURPOSE
//  Serial return-path transmitter for the transmit/receive channel. Accepts each
//  10-bit word the receiver delivers (data_valid + data_out) and queues it in a
//  small FIFO. Sends each word back over one wire as a framed serial character:
//  start bit, 10 data bits LSB first, even parity, stop bit.
//  A receiving deserializer sits at the far end of tx_out.
// PARAMETERS
//  DATA_W      10  word width; a frame is DATA_W+3 bits
//  BAUD_DIV    4   clk cycles per serial bit (>=1)
//  FIFO_DEPTH  4   queued words (power of 2, >=2)
// PORTS
//  clk         in   1       system clock; all logic on rising edge
//  clr         in   1       synchronous active-high reset
//  data_valid  in   1       1-cycle strobe: data_in holds a word to queue
//  data_in     in   DATA_W  word to send, sampled when data_valid=1
//  enable      in   1       1 = may start new frames; 0 = finish current, hold queue
//  tx_out      out  1       serial line; idle/stop = 1, start = 0 (registered)
//  busy        out  1       1 while a frame is on the line
//  fifo_full   out  1       FIFO holds FIFO_DEPTH words
//  overflow    out  1       sticky: a word was dropped; cleared only by clr
// BEHAVIOUR
//  Reset (clr=1 at an edge): tx_out=1, busy=0, fifo_full=0, overflow=0, FIFO empty,
//   FSM=IDLE, bit/baud counters=0. clr beats all other inputs. clr mid-frame aborts
//   the frame: tx_out=1 from the next edge, and all queued words are discarded.
//  FIFO write: data_valid=1 and not full -> push data_in. If full and a pop
//   happens at the same edge, the write is accepted. If full with no pop, the word
//   is dropped and overflow<=1.
//  Pop: at the edge where the FSM leaves IDLE, or leaves STOP straight into START.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//   IDLE:   tx_out=1. Go to START when FIFO non-empty and enable=1. Pop the head
//           into the shift register and latch parity = ^word.
//   START:  tx_out=0 for BAUD_DIV cycles -> DATA.
//   DATA:   tx_out=shift[0], BAUD_DIV cycles per bit. Shift right after each bit.
//           After DATA_W bits -> PARITY.
//   PARITY: tx_out = XOR of all data bits (even parity), BAUD_DIV cycles -> STOP.
//   STOP:   tx_out=1 for BAUD_DIV cycles. Then go to START (back-to-back, no idle
//           gap) if FIFO non-empty and enable=1, else go to IDLE.
//  busy=1 in START/DATA/PARITY/STOP. Frame length = (DATA_W+3)*BAUD_DIV cycles.
//  Latency: word strobed at edge E0 into an idle block with enable=1 -> tx_out=0
//   and busy=1 from edge E1.
//  enable=0 never truncates a frame. It only blocks the IDLE->START and
//   STOP->START transitions.
//  Baud counter runs 0..BAUD_DIV-1 and wraps. The bit counter wraps at DATA_W.
//   The FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, so full vs empty is
//   unambiguous.
// TESTING (DATA_W=10, BAUD_DIV=4, FIFO_DEPTH=4)
//  1 clr 2 cycles; one strobe data_in=10'h2A5 -> tx_out for 4 cycles each:
//    0,1,0,1,0,0,1,0,1,0,1,1(parity),1(stop); busy high exactly 52 cycles
//  2 three strobes on consecutive cycles (10'h001,10'h002,10'h3FF) -> three frames
//    back-to-back, busy high 156 cycles, parity bits 1,1,0; overflow stays 0
//  3 enable=0, five strobes on consecutive cycles -> fifo_full=1 after 4th,
//    5th dropped, overflow=1; enable=1 -> exactly 4 frames, overflow stays 1
//  4 clr asserted during data bit 5 of a frame with 2 words queued -> next edge
//    tx_out=1, busy=0, fifo_full=0, overflow=0; no further frames sent
//  5 enable dropped mid-DATA with 1 word queued -> current frame completes with
//    stop bit, line idles 1; enable=1 -> queued frame starts 1 cycle later
//  6 FIFO full, strobe on the same edge as a pop -> word accepted, overflow stays 0

Source files
------------

// File: rtl/frame_transmit_bdeduffy_if.sv
// rtl/frame_transmit_bdeduffy_if.sv - word input and serial line/status bundle for the return-path transmitter
interface frame_transmit_bdeduffy_if #(
    parameter int DATA_W = 10
);
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              enable;
    logic              tx_out;
    logic              busy;
    logic              fifo_full;
    logic              overflow;

    modport master (
        output data_valid,
        output data_in,
        output enable,
        input  tx_out,
        input  busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  data_valid,
        input  data_in,
        input  enable,
        output tx_out,
        output busy,
        output fifo_full,
        output overflow
    );
endinterface

// File: rtl/frame_transmit_bdeduffy.sv
// rtl/frame_transmit_bdeduffy.sv - queued serial return-path transmitter (start, data LSB first, even parity, stop)
module frame_transmit_bdeduffy #(
    parameter int DATA_W     = 10,
    parameter int BAUD_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                    clk,
    input logic                    clr,
    frame_transmit_bdeduffy_if.slave tx_if
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BTW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(DATA_W - 1);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BCW-1:0]    baud_q, baud_d;
    logic [BTW-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];

    logic              fifo_empty;
    logic              fifo_full;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              push;
    logic              baud_last;
    logic              can_start;
    logic [BCW-1:0]    baud_step;

    // Extra pointer MSB distinguishes a full queue from an empty one.
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (fifo_count == DEPTH_CNT);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

    assign baud_last = (baud_q == BAUD_LAST);
    assign baud_step = baud_last ? '0 : baud_q + 1'b1;
    assign can_start = !fifo_empty && tx_if.enable;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (can_start) begin
                    pop      = 1'b1;
                    state_d  = S_START;
                    shift_d  = fifo_head;
                    parity_d = ^fifo_head;
                end
            end
            S_START: begin
                baud_d = baud_step;
                if (baud_last) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_step;
                if (baud_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                baud_d = baud_step;
                if (baud_last) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                baud_d = baud_step;
                if (baud_last) begin
                    // Chain straight into the next start bit when a word is waiting.
                    if (can_start) begin
                        pop      = 1'b1;
                        state_d  = S_START;
                        shift_d  = fifo_head;
                        parity_d = ^fifo_head;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // Line level is derived from the next state so tx_out is a clean flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // A pop frees a slot at the same edge, so a write to a full queue still lands.
    always_comb begin
        push       = tx_if.data_valid && (!fifo_full || pop);
        overflow_d = overflow_q || (tx_if.data_valid && fifo_full && !pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = tx_if.data_in;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign tx_if.tx_out    = tx_q;
    assign tx_if.busy      = (state_q != S_IDLE);
    assign tx_if.fifo_full = fifo_full;
    assign tx_if.overflow  = overflow_q;
endmodule
